// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller and the pipeline registers it steers.
package hazard_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } mem_state_e;

  // x0 is hardwired zero, so a load targeting it never creates a dependency.
  localparam logic [4:0]  REG_ZERO  = 5'd0;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/load_use_detect.sv
// Combinational comparator: does the ID instruction read the register the EX-stage load writes?
module load_use_detect
  import hazard_pkg::*;
(
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic       ex_ld_valid,
  input  logic [4:0] ex_ld_rd,
  output logic       load_use
);

  logic rs1_hit, rs2_hit;

  assign rs1_hit  = id_use_rs1 && (id_rs1 == ex_ld_rd);
  assign rs2_hit  = id_use_rs2 && (id_rs2 == ex_ld_rd);
  assign load_use = id_valid && ex_ld_valid && (ex_ld_rd != REG_ZERO) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/hazard_control_unit.sv
// Stall/flush/freeze controller beside ID: load-use stalls, taken-branch flushes, memory-wait freezes.
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_mem_read,
  input  logic             ex_branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             pipe_freeze,
  output logic [CNT_W-1:0] stall_count,
  output logic             mem_timeout
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  logic              freeze, load_use;
  logic              ex_ld_valid;
  logic [4:0]        ex_ld_rd;
  mem_state_e        state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt;

  assign freeze = dmem_req && !dmem_ready;

  load_use_detect u_lud (
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .ex_ld_valid (ex_ld_valid),
    .ex_ld_rd    (ex_ld_rd),
    .load_use    (load_use)
  );

  // Branch is ignored under freeze: EX is held and re-presents it afterwards.
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    pipe_freeze  = 1'b0;
    if (freeze) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      pipe_freeze = 1'b1;
    end else if (ex_branch_taken) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (load_use) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end
  end

  // A bubbled slot never becomes a tracked load, so the stall lasts one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_ld_valid <= 1'b0;
      ex_ld_rd    <= 5'd0;
    end else if (!freeze) begin
      ex_ld_valid <= id_valid && id_mem_read && !id_ex_bubble;
      ex_ld_rd    <= id_rd;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (freeze) state_nxt = WAIT;
      WAIT:    if (dmem_ready) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  // wait_cnt sits at zero in RUN; timeout fires on the edge it reaches MEM_TIMEOUT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else if (state == RUN) begin
      wait_cnt <= '0;
    end else if (!dmem_ready) begin
      if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + WAIT_W'(1);
      if (wait_cnt >= WAIT_MAX - WAIT_W'(1)) mem_timeout <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_count <= '0;
    else if (!pc_write && (stall_count != {CNT_W{1'b1}}))
      stall_count <= stall_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit: vector table plus freeze/timeout/reset sequences.
module tb_hazard_control_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_valid = 1'b0;
  logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic        id_use_rs1 = 1'b0, id_use_rs2 = 1'b0, id_mem_read = 1'b0;
  logic        ex_branch_taken = 1'b0, dmem_req = 1'b0, dmem_ready = 1'b0;
  logic        pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze, mem_timeout;
  logic [31:0] stall_count;
  logic        s_pc_write, s_if_id_write, s_if_id_flush, s_id_ex_bubble, s_pipe_freeze, s_mem_timeout;
  logic [1:0]  s_stall_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_control_unit #(.CNT_W(32), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_mem_read(id_mem_read),
    .ex_branch_taken(ex_branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .pipe_freeze(pipe_freeze), .stall_count(stall_count),
    .mem_timeout(mem_timeout)
  );

  // Narrow counter copy to exercise stall_count saturation.
  hazard_control_unit #(.CNT_W(2), .MEM_TIMEOUT(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_mem_read(id_mem_read),
    .ex_branch_taken(ex_branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_write(s_pc_write), .if_id_write(s_if_id_write), .if_id_flush(s_if_id_flush),
    .id_ex_bubble(s_id_ex_bubble), .pipe_freeze(s_pipe_freeze), .stall_count(s_stall_count),
    .mem_timeout(s_mem_timeout)
  );

  // Expected output patterns {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze}
  localparam logic [4:0] NRM = 5'b11000;
  localparam logic [4:0] LU  = 5'b00010;
  localparam logic [4:0] BR  = 5'b11110;
  localparam logic [4:0] FRZ = 5'b00001;

  typedef struct {
    logic       v;
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [4:0] rd;
    logic       mr, br, dq, dr;
    logic [4:0] exp_out;
    int         exp_sc;
  } vec_t;

  vec_t vecs[19];

  function automatic vec_t mk(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic u1, input logic u2, input logic [4:0] rd,
                              input logic mr, input logic br, input logic dq, input logic dr,
                              input logic [4:0] eo, input int sc);
    vec_t r;
    r.v = v; r.rs1 = rs1; r.rs2 = rs2; r.u1 = u1; r.u2 = u2; r.rd = rd;
    r.mr = mr; r.br = br; r.dq = dq; r.dr = dr; r.exp_out = eo; r.exp_sc = sc;
    return r;
  endfunction

  function automatic logic [4:0] outs();
    return {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t r);
    id_valid = r.v; id_rs1 = r.rs1; id_rs2 = r.rs2; id_use_rs1 = r.u1; id_use_rs2 = r.u2;
    id_rd = r.rd; id_mem_read = r.mr; ex_branch_taken = r.br; dmem_req = r.dq; dmem_ready = r.dr;
  endtask

  initial begin
    //            v rs1 rs2 u1 u2 rd mr br dq dr  out  sc
    vecs[0]  = mk(1, 0,  0,  0, 0, 5, 1, 0, 0, 0, NRM, 0); // lw x5
    vecs[1]  = mk(1, 5,  0,  1, 0, 6, 0, 0, 0, 0, LU,  0); // add uses x5 -> stall
    vecs[2]  = mk(1, 5,  0,  1, 0, 6, 0, 0, 0, 0, NRM, 1); // re-presented, no stall
    vecs[3]  = mk(1, 0,  0,  0, 0, 0, 1, 0, 0, 0, NRM, 1); // lw x0
    vecs[4]  = mk(1, 0,  0,  1, 0, 7, 1, 0, 0, 0, NRM, 1); // reads x0: never stalls
    vecs[5]  = mk(1, 3,  7,  1, 0, 8, 1, 0, 0, 0, NRM, 1); // rs2 match but unused
    vecs[6]  = mk(1, 0,  8,  0, 1, 9, 1, 1, 0, 0, BR,  1); // load-use + branch: branch wins
    vecs[7]  = mk(1, 9,  0,  1, 0, 10,1, 0, 0, 0, NRM, 1); // flushed load not tracked
    vecs[8]  = mk(0, 10, 0,  1, 0, 0, 0, 0, 0, 0, NRM, 1); // id_valid=0 gates stall
    vecs[9]  = mk(1, 0,  0,  0, 0, 12,1, 0, 0, 0, NRM, 1); // lw x12
    vecs[10] = mk(1, 12, 0,  1, 0, 13,0, 0, 1, 0, FRZ, 1); // freeze beats load-use
    vecs[11] = mk(1, 12, 0,  1, 0, 13,0, 0, 1, 0, FRZ, 2);
    vecs[12] = mk(1, 12, 0,  1, 0, 13,0, 0, 1, 0, FRZ, 3);
    vecs[13] = mk(1, 12, 0,  1, 0, 13,0, 0, 1, 1, LU,  4); // tracker held through freeze
    vecs[14] = mk(1, 12, 0,  1, 0, 13,0, 0, 0, 0, NRM, 5);
    vecs[15] = mk(1, 0,  0,  0, 0, 0, 0, 1, 1, 0, FRZ, 5); // branch ignored while frozen
    vecs[16] = mk(1, 0,  0,  0, 0, 0, 0, 1, 1, 0, FRZ, 6);
    vecs[17] = mk(1, 0,  0,  0, 0, 0, 0, 1, 1, 1, BR,  7); // ready same cycle: flush now
    vecs[18] = mk(1, 0,  0,  0, 0, 0, 0, 0, 0, 0, NRM, 7);

    // Reset state
    #3;
    chk("reset_outs", 64'(outs()), 64'(NRM));
    chk("reset_stall_count", 64'(stall_count), 64'd0);
    chk("reset_mem_timeout", 64'(mem_timeout), 64'd0);
    @(negedge clk); rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i]);
      #2;
      chk($sformatf("vec%0d_outs", i), 64'(outs()), 64'(vecs[i].exp_out));
      chk($sformatf("vec%0d_stall_count", i), 64'(stall_count), 64'(vecs[i].exp_sc));
      chk($sformatf("vec%0d_mem_timeout", i), 64'(mem_timeout), 64'd0);
    end

    // Long wait: timeout rises after 4 WAIT cycles and is sticky
    id_valid = 1'b0; ex_branch_taken = 1'b0; id_mem_read = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      dmem_req = 1'b1; dmem_ready = 1'b0;
      #2;
      chk($sformatf("to%0d_freeze", k), 64'(outs()), 64'(FRZ));
      chk($sformatf("to%0d_mem_timeout", k), 64'(mem_timeout), 64'(k >= 5));
      chk($sformatf("to%0d_stall_count", k), 64'(stall_count), 64'(7 + k));
    end
    @(negedge clk);
    dmem_ready = 1'b1;
    #2;
    chk("to_ready_outs", 64'(outs()), 64'(NRM));
    chk("to_ready_stall_count", 64'(stall_count), 64'd17);
    chk("sat_stall_count", 64'(s_stall_count), 64'd3);
    @(negedge clk);
    dmem_req = 1'b0; dmem_ready = 1'b0;
    #2;
    chk("to_sticky", 64'(mem_timeout), 64'd1);

    // Asynchronous reset in the middle of a wait
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      dmem_req = 1'b1; dmem_ready = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("rst_stall_count", 64'(stall_count), 64'd0);
    chk("rst_sat_stall_count", 64'(s_stall_count), 64'd0);
    chk("rst_mem_timeout", 64'(mem_timeout), 64'd0);
    chk("rst_freeze_comb", 64'(outs()), 64'(FRZ));
    dmem_req = 1'b0;
    #1;
    chk("rst_outs_idle", 64'(outs()), 64'(NRM));
    @(negedge clk); rst_n = 1'b1;

    // After reset the FSM starts from RUN, so a new wait takes the full count again
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      dmem_req = 1'b1; dmem_ready = 1'b0;
      #2;
      chk($sformatf("post%0d_mem_timeout", k), 64'(mem_timeout), 64'(k >= 5));
    end
    @(negedge clk);
    dmem_req = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule

// File: doc/hazard_control_unit.md
# hazard_control_unit

Pipeline hazard and stall controller for the 5-stage pipelined CPU. It sits beside the ID stage and is the control counterpart of operand forwarding. It resolves every hazard that forwarding cannot cover: load-use stalls, branch-taken flushes, and whole-pipeline freezes while a variable-latency data memory is busy. It tracks in-flight loads itself and keeps a saturating stall-cycle counter and a sticky memory-timeout flag.

## Interface
Parameters:
- CNT_W, 32, width of stall_count
- MEM_TIMEOUT, 255, number of WAIT cycles before mem_timeout is set (≥1)

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  IF/ID holds a real instruction
- id_rs1, id_rs2  in  5  source register indices in ID
- id_use_rs1, id_use_rs2  in  1  instruction actually reads rs1 / rs2
- id_rd  in  5  destination register index in ID
- id_mem_read  in  1  ID instruction is a load
- ex_branch_taken  in  1  branch/jump resolved taken in EX
- dmem_req  in  1  MEM stage holds a load or store this cycle
- dmem_ready  in  1  data memory completes the MEM access this cycle
- pc_write  out  1  PC may update
- if_id_write  out  1  IF/ID may load
- if_id_flush  out  1  IF/ID loads a NOP
- id_ex_bubble  out  1  ID/EX loads a NOP (control bits zeroed)
- pipe_freeze  out  1  every pipeline register from ID/EX through MEM/WB holds
- stall_count  out  CNT_W  saturating count of cycles with pc_write=0
- mem_timeout  out  1  sticky flag, set when a memory wait exceeds MEM_TIMEOUT

## Operation
- Internal load tracker: ex_ld_valid, ex_ld_rd (5b), which describe the load currently in EX.
- freeze = dmem_req & ~dmem_ready.
- load_use = id_valid & ex_ld_valid & (ex_ld_rd≠0) & ((id_use_rs1 & id_rs1==ex_ld_rd) | (id_use_rs2 & id_rs2==ex_ld_rd)).
- Output priority is freeze > branch > load-use > normal.
  - freeze: pc_write=0, if_id_write=0, if_id_flush=0, id_ex_bubble=0, pipe_freeze=1. ex_branch_taken is ignored because EX is held and will re-present it.
  - branch: pc_write=1, if_id_write=1, if_id_flush=1, id_ex_bubble=1. Any load_use is discarded.
  - load-use: pc_write=0, if_id_write=0, id_ex_bubble=1, if_id_flush=0.
  - normal: pc_write=1, if_id_write=1, all other outputs 0.
- Tracker update on each edge:
  - When frozen, the tracker holds.
  - Otherwise ex_ld_valid ← id_valid & id_mem_read & ~id_ex_bubble, and ex_ld_rd ← id_rd.
  - A bubbled or flushed slot therefore never counts as a load, so a load-use stall lasts exactly 1 cycle.
- Loads whose data is in MEM or WB need no stall; forwarding covers them.
- Memory FSM (states RUN, WAIT):
  - RUN→WAIT when freeze is asserted; wait_cnt is cleared.
  - WAIT→RUN on dmem_ready.
  - WAIT self-loop increments wait_cnt, saturating at MEM_TIMEOUT.
  - mem_timeout ← 1 when wait_cnt reaches MEM_TIMEOUT in WAIT. It clears only on reset, and freeze continues while it is set.
- stall_count increments by 1 on each edge where pc_write=0, saturating at all-ones.

## Timing
- All hazard outputs are combinational from current inputs and tracker state, so the decision applies in the same cycle.
- Reset (rst_n=0, asynchronous): ex_ld_valid=0, ex_ld_rd=0, FSM=RUN, wait_cnt=0, stall_count=0, mem_timeout=0. With dmem_req=0 this gives pc_write=1, if_id_write=1, and all other outputs 0.
- Load-use penalty is 1 cycle. Branch penalty is 2 flushed slots (IF/ID and ID/EX) in 1 cycle.
- dmem_ready in the same cycle as dmem_req means no freeze and the FSM stays in RUN.
- Branch and load-use in the same cycle: branch wins, and the next cycle shows no load-use because the tracker is cleared.
- Reset during WAIT: FSM returns to RUN immediately. freeze still follows dmem_req/dmem_ready combinationally.
- rd=0 load never stalls.

## Structure
- hazard_pkg holds the FSM state enum (RUN, WAIT) and the NOP-related constants shared with the pipeline registers.
- One sub-module, load_use_detect, which is the pure combinational comparator producing load_use. The FSM, tracker and counters stay in the top level.
- wait_cnt width is $clog2(MEM_TIMEOUT+1).

## Test plan
- Load-use hazard: lw x5 in ID (id_mem_read=1, id_rd=5), next cycle add with id_rs1=5, id_use_rs1=1 → that cycle pc_write=0, if_id_write=0, id_ex_bubble=1. Following cycle all normal. stall_count=1.
- Load into x0, or consumer with id_use_rs2=0 and rs2 match → no stall; pc_write remains 1.
- ex_branch_taken=1 together with a load_use condition → if_id_flush=1, id_ex_bubble=1, pc_write=1. Next cycle no stall.
- dmem_req=1, dmem_ready=0 for 3 cycles, then 1 → pipe_freeze=1 for 3 cycles, FSM in WAIT. On the ready cycle pipe_freeze=0. stall_count=3. A branch asserted during the freeze produces no flush until the freeze ends.
- MEM_TIMEOUT=4, dmem_ready held 0 for 10 cycles → mem_timeout rises after 4 WAIT cycles and stays 1 after ready. rst_n pulse low mid-wait → all state and counters return to their reset values asynchronously.
